// File: rtl/mem_wb_stage.sv
// Memory/writeback stage. It retires ALU results one cycle after accept, and retires loads on the dcache dataOk cycle.
// allowin is combinational: the stage accepts when empty or retiring, so retire and accept can overlap with no bubble.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int GPR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              REEXE_valid_w_i,
  output logic              MEM_allowin_w_o,
  input  logic [GPR_W-1:0]  REEXE_writeNum_i,
  input  logic [DATA_W-1:0] REEXE_VAddr_i,
  input  logic [DATA_W-1:0] REEXE_regData_i,
  input  logic              REEXE_isLoad_i,
  input  logic [2:0]        REEXE_loadMode_i,
  input  logic [1:0]        REEXE_loadAddrLow_i,
  input  logic              dcache_dataOk_w_i,
  input  logic [DATA_W-1:0] dcache_rdata_i,
  output logic              MEM_forwardMode_w_o,
  output logic [GPR_W-1:0]  MEM_writeNum_w_o,
  output logic [DATA_W-1:0] MEM_forwardData_w_o,
  output logic              rf_wen_o,
  output logic [GPR_W-1:0]  rf_wnum_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [DATA_W-1:0] debug_wb_pc_o,
  output logic [31:0]       retireCnt_o
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;

  state_t            state;
  logic [GPR_W-1:0]  wnum_q;
  logic [DATA_W-1:0] vaddr_q;
  logic [DATA_W-1:0] regdata_q;
  logic [2:0]        mode_q;
  logic [1:0]        alow_q;
  logic [31:0]       cnt_q;

  logic              retire;
  logic              accept;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] ret_data;

  assign retire          = (state == S_READY) || ((state == S_WAIT) && dcache_dataOk_w_i);
  assign MEM_allowin_w_o = (state == S_EMPTY) || retire;
  assign accept          = REEXE_valid_w_i && MEM_allowin_w_o;

  always_comb begin
    byte_sel = dcache_rdata_i[7:0];
    case (alow_q)
      2'd1:    byte_sel = dcache_rdata_i[15:8];
      2'd2:    byte_sel = dcache_rdata_i[23:16];
      2'd3:    byte_sel = dcache_rdata_i[31:24];
      default: byte_sel = dcache_rdata_i[7:0];
    endcase
    half_sel = alow_q[1] ? dcache_rdata_i[31:16] : dcache_rdata_i[15:0];
  end

  // Undefined modes 5-7 fall through to the full-word case.
  always_comb begin
    load_ext = dcache_rdata_i;
    case (mode_q)
      3'd0:    load_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {{(DATA_W-8){1'b0}}, byte_sel};
      3'd2:    load_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'd3:    load_ext = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_ext = dcache_rdata_i;
    endcase
  end

  // Only loads ever sit in WAIT, so the state alone selects the load path.
  assign ret_data = (state == S_WAIT) ? load_ext : regdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      wnum_q    <= '0;
      vaddr_q   <= '0;
      regdata_q <= '0;
      mode_q    <= '0;
      alow_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (retire) cnt_q <= cnt_q + 32'd1;
      if (accept) begin
        wnum_q    <= REEXE_writeNum_i;
        vaddr_q   <= REEXE_VAddr_i;
        regdata_q <= REEXE_regData_i;
        mode_q    <= REEXE_loadMode_i;
        alow_q    <= REEXE_loadAddrLow_i;
        state     <= REEXE_isLoad_i ? S_WAIT : S_READY;
      end else if (retire) begin
        wnum_q <= '0;
        state  <= S_EMPTY;
      end
    end
  end

  assign MEM_forwardMode_w_o = retire;
  assign MEM_writeNum_w_o    = wnum_q;
  assign MEM_forwardData_w_o = ret_data;
  assign rf_wen_o            = retire && (wnum_q != '0);
  assign rf_wnum_o           = wnum_q;
  assign rf_wdata_o          = ret_data;
  assign debug_wb_pc_o       = vaddr_q;
  assign retireCnt_o         = cnt_q;

endmodule
